// File: rtl/tri_dispatch_ctrl_pkg.sv
// Shared definitions for the triangle dispatch controller: FSM state encoding,
// default parameter values and a select-width helper.
package tri_dispatch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    FETCH,
    LAUNCH,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_NUM_T_PIPES                 = 2;
  localparam int DEF_DATA_WIDTH                  = 32;
  localparam int DEF_MAIN_MEM_ADDR_WIDTH         = 32;
  localparam int DEF_LOCAL_VERTEX_MEM_ADDR_WIDTH = 4;
  localparam int DEF_TRI_CNT_WIDTH               = 16;

  // Width of a pipe index; a single pipe still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tri_dispatch_ctrl_if.sv
// Main memory read port, local vertex memory write port and triangle pipe
// start/done strobes, grouped as one bundle between dispatcher and fabric.
interface tri_dispatch_ctrl_if #(
  parameter int NUM_T_PIPES                 = 2,
  parameter int DATA_WIDTH                  = 32,
  parameter int MAIN_MEM_ADDR_WIDTH         = 32,
  parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH = 4
);

  logic                                   mem_rd_en;
  logic [MAIN_MEM_ADDR_WIDTH-1:0]         mem_rd_addr;
  logic [DATA_WIDTH-1:0]                  mem_rd_data;
  logic [NUM_T_PIPES-1:0]                 lvm_wr_en;
  logic [LOCAL_VERTEX_MEM_ADDR_WIDTH+1:0] lvm_wr_addr;
  logic [DATA_WIDTH-1:0]                  lvm_wr_data;
  logic [NUM_T_PIPES-1:0]                 t_pipe_start;
  logic [NUM_T_PIPES-1:0]                 t_pipe_done;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output lvm_wr_en, lvm_wr_addr, lvm_wr_data,
    output t_pipe_start,
    input  t_pipe_done
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  lvm_wr_en, lvm_wr_addr, lvm_wr_data,
    input  t_pipe_start,
    output t_pipe_done
  );

endinterface

// File: rtl/tri_dispatch_ctrl_rr_free_pick.sv
// Round-robin free-pipe picker: the first non-busy pipe found scanning
// upward from last_sel+1, wrapping, with last_sel itself checked last.
module rr_free_pick #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  busy,
  input  logic [SW-1:0] last_sel,
  output logic          found,
  output logic [SW-1:0] sel
);

  logic [SW-1:0] idx;

  // Scan from the farthest offset down so the nearest free pipe is assigned last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int off = N; off >= 1; off--) begin
      idx = SW'((int'(last_sel) + off) % N);
      if (!busy[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/tri_dispatch_ctrl.sv
// Triangle dispatcher: copies each triangle's vertex words from main memory
// into a free pipe's local vertex memory, then pulses that pipe's start.
module tri_dispatch_ctrl
  import tri_dispatch_ctrl_pkg::*;
#(
  parameter int NUM_T_PIPES                 = DEF_NUM_T_PIPES,
  parameter int DATA_WIDTH                  = DEF_DATA_WIDTH,
  parameter int MAIN_MEM_ADDR_WIDTH         = DEF_MAIN_MEM_ADDR_WIDTH,
  parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH = DEF_LOCAL_VERTEX_MEM_ADDR_WIDTH,
  parameter int TRI_CNT_WIDTH               = DEF_TRI_CNT_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   en,
  input  logic                                   start,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0]         v_array_ptr,
  input  logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] vertexSize,
  input  logic [TRI_CNT_WIDTH-1:0]               num_tris,
  output logic                                   busy,
  output logic                                   all_done,
  tri_dispatch_ctrl_if.master                    bus
);

  localparam int SW  = sel_width(NUM_T_PIPES);
  localparam int CW  = LOCAL_VERTEX_MEM_ADDR_WIDTH + 2;
  localparam int MAW = MAIN_MEM_ADDR_WIDTH;

  state_t                   state_reg;
  logic [TRI_CNT_WIDTH-1:0] tri_idx_reg;
  logic [TRI_CNT_WIDTH-1:0] num_tris_reg;
  logic [MAW-1:0]           tri_base_reg;
  logic [CW-1:0]            w_reg;
  logic [CW-1:0]            rd_k_reg;
  logic [SW-1:0]            sel_reg;
  logic [SW-1:0]            last_sel_reg;
  logic [NUM_T_PIPES-1:0]   pipe_busy_reg;
  logic                     fetch_last_reg;
  logic                     mem_rd_en_reg;
  logic [MAW-1:0]           mem_rd_addr_reg;
  logic [NUM_T_PIPES-1:0]   lvm_wr_en_reg;
  logic [CW-1:0]            lvm_wr_addr_reg;
  logic [NUM_T_PIPES-1:0]   t_pipe_start_reg;
  logic                     busy_reg;
  logic                     all_done_reg;

  logic [CW-1:0]            w_calc;
  logic [NUM_T_PIPES-1:0]   sel_onehot;
  logic                     pick_found;
  logic [SW-1:0]            pick_sel;
  logic                     wr_last_now;
  logic [DATA_WIDTH-1:0]    rd_data;

  // 3*(vertexSize+1) always fits in LVW+2 bits since 3*2^LVW < 4*2^LVW.
  assign w_calc      = CW'(3) * (CW'(vertexSize) + CW'(1));
  assign wr_last_now = (|lvm_wr_en_reg) && (lvm_wr_addr_reg == w_reg - CW'(1));
  assign rd_data     = bus.mem_rd_data;

  for (genvar gi = 0; gi < NUM_T_PIPES; gi++) begin : g_onehot
    assign sel_onehot[gi] = (sel_reg == SW'(gi));
  end

  rr_free_pick #(
    .N  (NUM_T_PIPES),
    .SW (SW)
  ) u_pick (
    .busy     (pipe_busy_reg),
    .last_sel (last_sel_reg),
    .found    (pick_found),
    .sel      (pick_sel)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      tri_idx_reg      <= '0;
      num_tris_reg     <= '0;
      tri_base_reg     <= '0;
      w_reg            <= '0;
      rd_k_reg         <= '0;
      sel_reg          <= '0;
      last_sel_reg     <= SW'(NUM_T_PIPES - 1);
      pipe_busy_reg    <= '0;
      fetch_last_reg   <= 1'b0;
      mem_rd_en_reg    <= 1'b0;
      mem_rd_addr_reg  <= '0;
      lvm_wr_en_reg    <= '0;
      lvm_wr_addr_reg  <= '0;
      t_pipe_start_reg <= '0;
      busy_reg         <= 1'b0;
      all_done_reg     <= 1'b0;
    end else begin
      // Done pulses, start pulses and in-flight writes keep running while en is low.
      pipe_busy_reg    <= (pipe_busy_reg & ~bus.t_pipe_done) | t_pipe_start_reg;
      t_pipe_start_reg <= '0;
      mem_rd_en_reg    <= 1'b0;
      mem_rd_addr_reg  <= '0;
      lvm_wr_en_reg    <= mem_rd_en_reg ? sel_onehot : '0;
      lvm_wr_addr_reg  <= mem_rd_en_reg ? rd_k_reg - CW'(1) : '0;
      if (wr_last_now) begin
        fetch_last_reg <= 1'b1;
      end

      if (en) begin
        case (state_reg)
          IDLE, DONE: begin
            if (start) begin
              num_tris_reg <= num_tris;
              w_reg        <= w_calc;
              tri_idx_reg  <= '0;
              tri_base_reg <= v_array_ptr;
              all_done_reg <= 1'b0;
              busy_reg     <= 1'b1;
              state_reg    <= (num_tris == '0) ? DRAIN : SELECT;
            end
          end
          SELECT: begin
            if (pick_found) begin
              sel_reg        <= pick_sel;
              rd_k_reg       <= '0;
              fetch_last_reg <= 1'b0;
              state_reg      <= FETCH;
            end
          end
          FETCH: begin
            if (rd_k_reg != w_reg) begin
              mem_rd_en_reg   <= 1'b1;
              mem_rd_addr_reg <= tri_base_reg + MAW'(rd_k_reg);
              rd_k_reg        <= rd_k_reg + CW'(1);
            end
            // Leave only after the last word has landed in local memory.
            if (wr_last_now || fetch_last_reg) begin
              t_pipe_start_reg <= sel_onehot;
              tri_idx_reg      <= tri_idx_reg + TRI_CNT_WIDTH'(1);
              tri_base_reg     <= tri_base_reg + MAW'(w_reg);
              last_sel_reg     <= sel_reg;
              state_reg        <= LAUNCH;
            end
          end
          LAUNCH: begin
            state_reg <= (tri_idx_reg == num_tris_reg) ? DRAIN : SELECT;
          end
          DRAIN: begin
            if (pipe_busy_reg == '0) begin
              all_done_reg <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= DONE;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mem_rd_en    = mem_rd_en_reg;
  assign bus.mem_rd_addr  = mem_rd_addr_reg;
  assign bus.lvm_wr_en    = lvm_wr_en_reg;
  assign bus.lvm_wr_addr  = lvm_wr_addr_reg;
  assign bus.lvm_wr_data  = (|lvm_wr_en_reg) ? rd_data : '0;
  assign bus.t_pipe_start = t_pipe_start_reg;
  assign busy             = busy_reg;
  assign all_done         = all_done_reg;

endmodule
